// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception vectors, exception codes and the
// instruction-memory window used by the fetch address check.
package cpu_pkg;

    typedef logic [4:0] exccode_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_ENTRY = 32'h0000_4180;

    localparam exccode_t EXCCODE_NONE = 5'd0;
    localparam exccode_t EXCCODE_ADEL = 5'd4;

    localparam logic [31:0] IMEM_LO = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI = 32'h0000_6FFC;

    // A misaligned PC is always AdEL; the window check is optional.
    function automatic exccode_t fetch_code(input logic [31:0] addr, input logic range_en);
        if (addr[1:0] != 2'b00) begin
            return EXCCODE_ADEL;
        end
        if (range_en && ((addr < IMEM_LO) || (addr > IMEM_HI))) begin
            return EXCCODE_ADEL;
        end
        return EXCCODE_NONE;
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Architectural PC register with the exception / eret / stall priority mux.
// Also reports whether this cycle redirects fetch, so IF/ID can flush.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_ENTRY = DEFAULT_EXC_ENTRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        redirect
);

    logic [31:0] pc_d;

    // Exception entry beats eret, and both override a hazard stall.
    always_comb begin
        pc_d = pc;
        if (exc_req) begin
            pc_d = EXC_ENTRY;
        end else if (eret_req) begin
            pc_d = epc;
        end else if (!stall) begin
            pc_d = next_pc;
        end
    end

    assign redirect = exc_req | eret_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register plus the IF/ID pipeline register.
// Define IF_RANGE_CHECK_EN to also flag fetches outside the imem window as AdEL.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_ENTRY = DEFAULT_EXC_ENTRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        id_is_jb,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_bd,
    output logic [4:0]  id_exccode,
    output logic        id_valid
);

`ifdef IF_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    logic        redirect;
    exccode_t    fetch_exc;
    logic [31:0] fetch_word;

    pc_reg #(
        .RESET_PC  (RESET_PC),
        .EXC_ENTRY (EXC_ENTRY)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .next_pc  (next_pc),
        .stall    (stall),
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc      (epc),
        .pc       (pc),
        .redirect (redirect)
    );

    assign imem_addr = pc;

    // A faulting fetch carries a nop forward; CP0 takes the exception later.
    always_comb begin
        fetch_exc  = fetch_code(pc, RANGE_CHECK);
        fetch_word = (fetch_exc == EXCCODE_NONE) ? imem_rdata : 32'h0000_0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_instr   <= 32'h0000_0000;
            id_pc      <= 32'h0000_0000;
            id_bd      <= 1'b0;
            id_exccode <= EXCCODE_NONE;
            id_valid   <= 1'b0;
        end else if (redirect) begin
            id_instr   <= 32'h0000_0000;
            id_pc      <= 32'h0000_0000;
            id_bd      <= 1'b0;
            id_exccode <= EXCCODE_NONE;
            id_valid   <= 1'b0;
        end else if (!stall) begin
            id_instr   <= fetch_word;
            id_pc      <= pc;
            id_bd      <= id_is_jb;
            id_exccode <= fetch_exc;
            id_valid   <= 1'b1;
        end
    end

    assign id_pc8 = id_pc + 32'd8;

endmodule
